fft_radix2_iter: RTL and testbench

//  Parametrised iterative radix-2 DIT FFT, N = 2**LOG2N complex points, one butterfly per cycle.

---
 rtl/fft_radix2_iter_if.sv | 28 ++
 rtl/fft_radix2_iter.sv | 193 +++++++++++++++++++
 tb/tb_fft_radix2_iter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/fft_radix2_iter_if.sv
// Streaming sample/bin bus of the iterative radix-2 FFT.
// slave: the FFT core; master: whoever feeds samples and drains bins.
interface fft_radix2_iter_if #(
    parameter int LOG2N = 3,
    parameter int DW    = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_real;
    logic [DW-1:0]    in_imag;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_real;
    logic [DW-1:0]    out_imag;
    logic [LOG2N-1:0] out_index;
    logic             busy;
    logic             ovf;

    modport slave (
        input  in_valid, in_real, in_imag, out_ready,
        output in_ready, out_valid, out_real, out_imag, out_index, busy, ovf
    );

    modport master (
        output in_valid, in_real, in_imag, out_ready,
        input  in_ready, out_valid, out_real, out_imag, out_index, busy, ovf
    );
endinterface

// File: rtl/fft_radix2_iter.sv
// Iterative in-place radix-2 DIT FFT, N = 2**LOG2N points, one butterfly per clock.
// Samples land in bit-reversed slots so bins come out in natural order.
// LOAD collects N samples, COMPUTE runs N/2*LOG2N butterflies, UNLOAD streams N bins.
module fft_radix2_iter #(
    parameter int LOG2N   = 3,
    parameter int DW      = 16,
    parameter int SCALE   = 0,
    parameter int SIGNMAG = 0
) (
    input logic              CLK,
    input logic              RST_N,
    fft_radix2_iter_if.slave bus
);
    localparam int N  = 1 << LOG2N;
    localparam int NB = N / 2;
    localparam int SW = (LOG2N > 2) ? 2 : 1;   // stage counter width
    localparam int BW = LOG2N - 1;             // butterfly counter width
    localparam int PW = DW + 17;               // complex product-sum width
    localparam int XW = DW + 3;                // butterfly sum width, no wrap possible

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_COMP = 2'd1;
    localparam logic [1:0] S_UNLD = 2'd2;

    localparam logic signed [XW-1:0] SMAX   = XW'(2**(DW-1) - 1);
    localparam logic signed [XW-1:0] SMIN   = XW'(-(2**(DW-1)));
    localparam logic signed [DW-1:0] MIN_DW = {1'b1, {(DW-1){1'b0}}};

    // Q1.15 twiddles W16^j = exp(-j*2*pi*j/16), j = 0..7
    localparam logic signed [15:0] TW_RE [8] = '{
        16'sd32767, 16'sd30274, 16'sd23170, 16'sd12540,
        16'sd0, -16'sd12540, -16'sd23170, -16'sd30274};
    localparam logic signed [15:0] TW_IM [8] = '{
        16'sd0, -16'sd12540, -16'sd23170, -16'sd30274,
        -16'sd32767, -16'sd30274, -16'sd23170, -16'sd12540};

    logic [1:0]              r_state;
    logic [LOG2N-1:0]        r_cnt;      // sample count in LOAD, bin index in UNLOAD
    logic [SW-1:0]           r_stage;
    logic [BW-1:0]           r_bfly;
    logic                    r_ovf;
    logic signed [DW-1:0]    r_re [N];
    logic signed [DW-1:0]    r_im [N];

    logic [LOG2N-1:0]        w_ia, w_ib;
    logic [2:0]              w_tw;
    logic signed [DW-1:0]    w_ar, w_ai, w_br, w_bi;
    logic signed [15:0]      w_wr, w_wi;
    logic signed [PW-1:0]    w_pr, w_pi;
    logic signed [XW-1:0]    w_tr, w_ti;
    logic signed [XW-1:0]    w_sar, w_sai, w_sbr, w_sbi;
    logic                    w_bf_ovf;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        for (int i = 0; i < LOG2N; i++) bitrev[i] = v[LOG2N-1-i];
    endfunction

    // Boundary conversion in; sign-magnitude -0 becomes plain 0
    function automatic logic signed [DW-1:0] to_int(input logic [DW-1:0] v);
        if (SIGNMAG == 0) return v;
        if (v[DW-1]) return -$signed({1'b0, v[DW-2:0]});
        return v;
    endfunction

    // Boundary conversion out; -2**(DW-1) has no magnitude form, clamp to all-ones
    function automatic logic [DW-1:0] to_ext(input logic signed [DW-1:0] v);
        logic [DW-1:0] m;
        if (SIGNMAG == 0) return v;
        if (v == MIN_DW) return '1;
        if (v < 0) begin
            m = -v;
            return {1'b1, m[DW-2:0]};
        end
        return v;
    endfunction

    function automatic logic signed [XW-1:0] post(input logic signed [XW-1:0] v);
        return (SCALE != 0) ? (v >>> 1) : v;
    endfunction

    function automatic logic oflow(input logic signed [XW-1:0] v);
        return (v > SMAX) || (v < SMIN);
    endfunction

    function automatic logic signed [DW-1:0] sat(input logic signed [XW-1:0] v);
        if (v > SMAX) return SMAX[DW-1:0];
        if (v < SMIN) return SMIN[DW-1:0];
        return v[DW-1:0];
    endfunction

    // Butterfly addressing and twiddle index from (stage, butterfly)
    always_comb begin
        int s, b, half, ia, k;
        s    = int'(r_stage);
        b    = int'(r_bfly);
        half = 1 << s;
        ia   = ((b >> s) << (s + 1)) + (b & (half - 1));
        k    = (b & (half - 1)) << (LOG2N - 1 - s);
        w_ia = LOG2N'(ia);
        w_ib = LOG2N'(ia + half);
        w_tw = 3'(k << (4 - LOG2N));
    end

    assign w_ar = r_re[w_ia];
    assign w_ai = r_im[w_ia];
    assign w_br = r_re[w_ib];
    assign w_bi = r_im[w_ib];
    assign w_wr = TW_RE[w_tw];
    assign w_wi = TW_IM[w_tw];

    // t = B*W, rounded half up back to integer scale
    assign w_pr = PW'(w_br) * PW'(w_wr) - PW'(w_bi) * PW'(w_wi) + PW'(16384);
    assign w_pi = PW'(w_br) * PW'(w_wi) + PW'(w_bi) * PW'(w_wr) + PW'(16384);
    assign w_tr = XW'(w_pr >>> 15);
    assign w_ti = XW'(w_pi >>> 15);

    assign w_sar = post(XW'(w_ar) + w_tr);
    assign w_sai = post(XW'(w_ai) + w_ti);
    assign w_sbr = post(XW'(w_ar) - w_tr);
    assign w_sbi = post(XW'(w_ai) - w_ti);

    assign w_bf_ovf = (SCALE == 0) &&
                      (oflow(w_sar) || oflow(w_sai) || oflow(w_sbr) || oflow(w_sbi));

    // Control FSM: counters, stage sequencing and sticky overflow
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= S_LOAD;
            r_cnt   <= '0;
            r_stage <= '0;
            r_bfly  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: if (bus.in_valid) begin
                    if (r_cnt == '0) r_ovf <= 1'b0;
                    if (r_cnt == LOG2N'(N - 1)) begin
                        r_cnt   <= '0;
                        r_state <= S_COMP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_COMP: begin
                    r_ovf <= r_ovf | w_bf_ovf;
                    if (r_bfly == BW'(NB - 1)) begin
                        r_bfly <= '0;
                        if (r_stage == SW'(LOG2N - 1)) begin
                            r_stage <= '0;
                            r_state <= S_UNLD;
                        end else begin
                            r_stage <= r_stage + 1'b1;
                        end
                    end else begin
                        r_bfly <= r_bfly + 1'b1;
                    end
                end
                S_UNLD: if (bus.out_ready) begin
                    if (r_cnt == LOG2N'(N - 1)) begin
                        r_cnt   <= '0;
                        r_state <= S_LOAD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

    // Sample store: bit-reversed writes in LOAD, in-place butterfly writes in COMPUTE
    always_ff @(posedge CLK) begin
        if (RST_N) begin
            if (r_state == S_LOAD && bus.in_valid) begin
                r_re[bitrev(r_cnt)] <= to_int(bus.in_real);
                r_im[bitrev(r_cnt)] <= to_int(bus.in_imag);
            end else if (r_state == S_COMP) begin
                r_re[w_ia] <= sat(w_sar);
                r_im[w_ia] <= sat(w_sai);
                r_re[w_ib] <= sat(w_sbr);
                r_im[w_ib] <= sat(w_sbi);
            end
        end
    end

    assign bus.in_ready  = RST_N && (r_state == S_LOAD);
    assign bus.out_valid = RST_N && (r_state == S_UNLD);
    assign bus.busy      = RST_N && (r_state == S_COMP);
    assign bus.out_real  = to_ext(r_re[r_cnt]);
    assign bus.out_imag  = to_ext(r_im[r_cnt]);
    assign bus.out_index = r_cnt;
    assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_fft_radix2_iter.sv
// Bench for fft_radix2_iter: three instances (full gain, scaled, sign-magnitude)
// fed the same frames; every bin is checked against a floating-point DFT.
module tb_fft_radix2_iter;
    localparam int LOG2N = 3;
    localparam int DW    = 16;
    localparam int N     = 8;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    fft_radix2_iter_if #(.LOG2N(LOG2N), .DW(DW)) bus0 (), bus1 (), bus2 ();

    fft_radix2_iter #(.LOG2N(LOG2N), .DW(DW), .SCALE(0), .SIGNMAG(0))
        u_fs (.CLK(CLK), .RST_N(RST_N), .bus(bus0));
    fft_radix2_iter #(.LOG2N(LOG2N), .DW(DW), .SCALE(1), .SIGNMAG(0))
        u_sc (.CLK(CLK), .RST_N(RST_N), .bus(bus1));
    fft_radix2_iter #(.LOG2N(LOG2N), .DW(DW), .SCALE(0), .SIGNMAG(1))
        u_sm (.CLK(CLK), .RST_N(RST_N), .bus(bus2));

    int  errors = 0;
    int  checks = 0;
    int  xr [N];
    int  xi [N];
    real er [N];
    real ei [N];

    task automatic chk(input string tag, input int obs, input int exp, input int tol);
        checks++;
        if (obs > exp + tol || obs < exp - tol) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    function automatic logic [15:0] sm_enc(input int v, input bit negzero);
        if (v < 0) return 16'(32768 | (-v));
        if (v == 0 && negzero) return 16'h8000;
        return 16'(v);
    endfunction

    function automatic int sm_dec(input logic [15:0] v);
        if (v[15]) return -int'(v[14:0]);
        return int'(v);
    endfunction

    function automatic int rnd(input real v);
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(-v + 0.5);
    endfunction

    function automatic int clampi(input int v, input int lo);
        if (v > 32767) return 32767;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic set_in(input bit v, input int r, input int i, input bit nz);
        bus0.in_valid = v; bus0.in_real = 16'(r); bus0.in_imag = 16'(i);
        bus1.in_valid = v; bus1.in_real = 16'(r); bus1.in_imag = 16'(i);
        bus2.in_valid = v; bus2.in_real = sm_enc(r, nz); bus2.in_imag = sm_enc(i, nz);
    endtask

    task automatic set_ordy(input bit v);
        bus0.out_ready = v; bus1.out_ready = v; bus2.out_ready = v;
    endtask

    // Reference: direct DFT X[k] = sum x[n] * exp(-j*2*pi*n*k/N)
    task automatic model;
        for (int k = 0; k < N; k++) begin
            real sr, si, th;
            sr = 0.0; si = 0.0;
            for (int n = 0; n < N; n++) begin
                th = 2.0 * 3.14159265358979 * real'(n * k) / real'(N);
                sr += real'(xr[n]) * $cos(th) + real'(xi[n]) * $sin(th);
                si += real'(xi[n]) * $cos(th) - real'(xr[n]) * $sin(th);
            end
            er[k] = sr; ei[k] = si;
        end
    endtask

    task automatic load_frame(input bit gaps);
        int w = 0;
        while (!bus0.in_ready && w < 50) begin tick; w++; end
        chk("in_ready_at_load", int'(bus0.in_ready), 1, 0);
        for (int n = 0; n < N; n++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                set_in(0, 'h1234, 'h0321, 0);
                tick;
                chk("in_ready_gap", int'(bus0.in_ready), 1, 0);
            end
            set_in(1, xr[n], xi[n], bit'($urandom_range(0, 1)));
            tick;
            if (n == 0) chk("ovf_clear_first", int'(bus0.ovf), 0, 0);
        end
        set_in(0, 0, 0, 0);
    endtask

    task automatic check_bin(input string nm, input int k, input int tol);
        int e0r, e0i, e2r, e2i;
        e0r = clampi(rnd(er[k]), -32768);
        e0i = clampi(rnd(ei[k]), -32768);
        e2r = clampi(rnd(er[k]), -32767);
        e2i = clampi(rnd(ei[k]), -32767);
        chk($sformatf("%s fs_re[%0d]", nm, k), int'($signed(bus0.out_real)), e0r, tol);
        chk($sformatf("%s fs_im[%0d]", nm, k), int'($signed(bus0.out_imag)), e0i, tol);
        chk($sformatf("%s sc_re[%0d]", nm, k), int'($signed(bus1.out_real)), rnd(er[k] / 8.0), tol);
        chk($sformatf("%s sc_im[%0d]", nm, k), int'($signed(bus1.out_imag)), rnd(ei[k] / 8.0), tol);
        chk($sformatf("%s sm_re[%0d]", nm, k), sm_dec(bus2.out_real), e2r, tol);
        chk($sformatf("%s sm_im[%0d]", nm, k), sm_dec(bus2.out_imag), e2i, tol);
        if (tol == 0) begin
            chk($sformatf("%s sm_raw_re[%0d]", nm, k), int'(bus2.out_real), int'(sm_enc(e2r, 0)), 0);
            chk($sformatf("%s sm_raw_im[%0d]", nm, k), int'(bus2.out_imag), int'(sm_enc(e2i, 0)), 0);
        end
    endtask

    task automatic run_frame(input string nm, input bit gaps, input bit junk,
                             input bit bp, input int tol, input int eovf);
        int cyc = 0;
        model;
        load_frame(gaps);
        if (junk) set_in(1, 12345, -2222, 0);
        while (bus0.busy && cyc < 100) begin tick; cyc++; end
        chk({nm, " compute_cycles"}, cyc, 12, 0);
        chk({nm, " in_ready_unload"}, int'(bus0.in_ready), 0, 0);
        set_ordy(1);
        for (int k = 0; k < N; k++) begin
            if (bp && k == 3) begin
                set_ordy(0);
                for (int c = 0; c < 5; c++) begin
                    tick;
                    chk({nm, " stall_index"}, int'(bus0.out_index), 3, 0);
                    chk({nm, " stall_valid"}, int'(bus0.out_valid), 1, 0);
                    chk({nm, " stall_in_ready"}, int'(bus0.in_ready), 0, 0);
                    check_bin({nm, " stall"}, 3, tol);
                end
                set_ordy(1);
            end
            chk($sformatf("%s out_index", nm), int'(bus0.out_index), k, 0);
            chk($sformatf("%s out_valid", nm), int'(bus0.out_valid & bus1.out_valid & bus2.out_valid), 1, 0);
            check_bin(nm, k, tol);
            tick;
        end
        set_in(0, 0, 0, 0);
        chk({nm, " out_valid_done"}, int'(bus0.out_valid), 0, 0);
        chk({nm, " in_ready_done"}, int'(bus0.in_ready), 1, 0);
        chk({nm, " ovf_fs"}, int'(bus0.ovf), eovf, 0);
        chk({nm, " ovf_sc"}, int'(bus1.ovf), 0, 0);
        chk({nm, " ovf_sm"}, int'(bus2.ovf), eovf, 0);
    endtask

    task automatic fill(input int v0, input int vrest);
        for (int n = 0; n < N; n++) begin
            xr[n] = (n == 0) ? v0 : vrest;
            xi[n] = 0;
        end
    endtask

    initial begin
        set_in(0, 0, 0, 0);
        set_ordy(0);
        RST_N = 1'b0;
        tick; tick;
        chk("rst in_ready", int'(bus0.in_ready), 0, 0);
        chk("rst out_valid", int'(bus0.out_valid), 0, 0);
        chk("rst busy", int'(bus0.busy), 0, 0);
        chk("rst ovf", int'(bus0.ovf), 0, 0);
        RST_N = 1'b1;
        #1;
        chk("post_rst in_ready", int'(bus0.in_ready), 1, 0);

        fill(1000, 0);      run_frame("impulse", 1, 0, 1, 0, 0);
        fill(1000, 1000);   run_frame("dc1000", 0, 0, 0, 3, 0);
        for (int n = 0; n < N; n++) begin
            xr[n] = rnd(8000.0 * $cos(2.0 * 3.14159265358979 * real'(n) / 8.0));
            xi[n] = 0;
        end
        run_frame("cos", 0, 1, 0, 3, 0);
        fill(20000, 20000); run_frame("dc20000", 0, 0, 0, 3, 1);
        fill(1000, 0);      run_frame("impulse2", 0, 0, 0, 0, 0);
        fill(-1000, 0);     run_frame("neg_impulse", 1, 1, 0, 0, 0);
        for (int f = 0; f < 3; f++) begin
            for (int n = 0; n < N; n++) begin
                xr[n] = int'($urandom_range(0, 3000)) - 1500;
                xi[n] = int'($urandom_range(0, 3000)) - 1500;
            end
            run_frame($sformatf("rand%0d", f), 1, 1, f == 1, 3, 0);
        end

        // Abort a frame mid-compute; nothing from it may surface
        for (int n = 0; n < N; n++) begin xr[n] = 777; xi[n] = -555; end
        load_frame(0);
        tick; tick; tick;
        chk("abort busy_before", int'(bus0.busy), 1, 0);
        RST_N = 1'b0;
        #1;
        chk("abort in_ready_low", int'(bus0.in_ready), 0, 0);
        chk("abort busy_low", int'(bus0.busy), 0, 0);
        tick; tick;
        chk("abort out_valid_low", int'(bus0.out_valid), 0, 0);
        RST_N = 1'b1;
        #1;
        chk("abort in_ready", int'(bus0.in_ready), 1, 0);
        chk("abort out_valid", int'(bus0.out_valid), 0, 0);
        chk("abort busy", int'(bus0.busy), 0, 0);
        fill(1000, 0);      run_frame("after_abort", 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
